// File: rtl/ofm_csum_gen.sv
// ofm_csum_gen -- TX L4 checksum engine (RFC1071 ones-complement sum per frame).
//
// Taps the MM2S data-FIFO write stream (never stalls it), pairs bytes relative
// to a per-frame begin offset, accumulates a 16-bit ones-complement sum seeded
// with a pseudo-header partial sum, and returns {checksum, insert offset, en}
// through a small result FIFO.
//
// Ports:
//   mm2s_clk, mm2s_resetn            clock, async active-low reset
//   cmd_valid/cmd_ready              descriptor push (en, begin, insert, init)
//   data_valid/data/data_keep/data_last   observed stream beat
//   res_valid/res_ready              result pop (res_sum, res_insert, res_en)
//   err_nocmd                        pulse: frame started with no descriptor queued
//   err_res_ovf                      pulse: result dropped, result FIFO full
//
// Build option: define CSUM_ZERO_FIX_EN to replace a computed 0x0000 checksum of
// an enabled frame with 0xFFFF (UDP transmits 0x0000 as "no checksum").
//
// Pipeline: S1 beat+mask reg, S2 beat partial sum, S3 frame accumulator,
// S4 fold/invert reg, then result FIFO write (res_valid 4 edges after last).

module ofm_csum_gen #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_CMD_DEPTH  = 4,
    parameter int C_RES_DEPTH  = 4
) (
    input  logic                      mm2s_clk,
    input  logic                      mm2s_resetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_en,
    input  logic [15:0]               cmd_begin,
    input  logic [15:0]               cmd_insert,
    input  logic [15:0]               cmd_init,
    input  logic                      data_valid,
    input  logic [C_DATA_WIDTH-1:0]   data,
    input  logic [C_DATA_WIDTH/8-1:0] data_keep,
    input  logic                      data_last,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [15:0]               res_sum,
    output logic [15:0]               res_insert,
    output logic                      res_en,
    output logic                      err_nocmd,
    output logic                      err_res_ovf
);

    localparam int KW  = C_DATA_WIDTH / 8;
    localparam int CAW = $clog2(C_CMD_DEPTH);
    localparam int RAW = $clog2(C_RES_DEPTH);

    // ------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------
    logic        cq_en     [C_CMD_DEPTH];
    logic [15:0] cq_begin  [C_CMD_DEPTH];
    logic [15:0] cq_insert [C_CMD_DEPTH];
    logic [15:0] cq_init   [C_CMD_DEPTH];
    logic [CAW:0] cq_wr, cq_rd;
    logic cq_empty, cq_full, cq_push, cq_pop;

    logic sof_q;

    assign cq_empty  = (cq_wr == cq_rd);
    assign cq_full   = (cq_wr[CAW] != cq_rd[CAW]) && (cq_wr[CAW-1:0] == cq_rd[CAW-1:0]);
    assign cmd_ready = !cq_full;
    assign cq_push   = cmd_valid && !cq_full;
    assign cq_pop    = data_valid && sof_q && !cq_empty;

    always_ff @(posedge mm2s_clk) begin
        if (cq_push) begin
            cq_en[cq_wr[CAW-1:0]]     <= cmd_en;
            cq_begin[cq_wr[CAW-1:0]]  <= cmd_begin;
            cq_insert[cq_wr[CAW-1:0]] <= cmd_insert;
            cq_init[cq_wr[CAW-1:0]]   <= cmd_init;
        end
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            cq_wr <= '0;
            cq_rd <= '0;
        end else begin
            if (cq_push) cq_wr <= cq_wr + 1'b1;
            if (cq_pop)  cq_rd <= cq_rd + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame tracking and per-beat descriptor selection
    // ------------------------------------------------------------------
    logic [15:0] off_q;
    logic        fr_en;
    logic [15:0] fr_begin, fr_insert, fr_init;
    logic        d_en;
    logic [15:0] d_begin, d_insert, d_init;
    logic [KW-1:0] d_mask;

    // The first beat of a frame takes its descriptor straight from the FIFO
    // head (or an all-zero one when nothing is queued); later beats reuse the
    // copy latched on that first beat.
    always_comb begin
        d_en     = fr_en;
        d_begin  = fr_begin;
        d_insert = fr_insert;
        d_init   = fr_init;
        if (sof_q) begin
            d_en     = 1'b0;
            d_begin  = '0;
            d_insert = '0;
            d_init   = '0;
            if (!cq_empty) begin
                d_en     = cq_en[cq_rd[CAW-1:0]];
                d_begin  = cq_begin[cq_rd[CAW-1:0]];
                d_insert = cq_insert[cq_rd[CAW-1:0]];
                d_init   = cq_init[cq_rd[CAW-1:0]];
            end
        end
    end

    always_comb begin
        d_mask = '0;
        for (int i = 0; i < KW; i++) begin
            d_mask[i] = data_keep[i] && (({1'b0, off_q} + 17'(i)) >= {1'b0, d_begin});
        end
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            sof_q     <= 1'b1;
            off_q     <= '0;
            fr_en     <= 1'b0;
            fr_begin  <= '0;
            fr_insert <= '0;
            fr_init   <= '0;
            err_nocmd <= 1'b0;
        end else begin
            err_nocmd <= data_valid && sof_q && cq_empty;
            if (data_valid) begin
                sof_q <= data_last;
                off_q <= data_last ? 16'd0 : off_q + 16'(KW);
                if (sof_q) begin
                    fr_en     <= d_en;
                    fr_begin  <= d_begin;
                    fr_insert <= d_insert;
                    fr_init   <= d_init;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: register beat and byte mask
    // ------------------------------------------------------------------
    logic                    s1_valid, s1_sof, s1_last, s1_swap, s1_en;
    logic [C_DATA_WIDTH-1:0] s1_data;
    logic [KW-1:0]           s1_mask;
    logic [15:0]             s1_insert, s1_init;

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_last   <= 1'b0;
            s1_swap   <= 1'b0;
            s1_en     <= 1'b0;
            s1_data   <= '0;
            s1_mask   <= '0;
            s1_insert <= '0;
            s1_init   <= '0;
        end else begin
            s1_valid  <= data_valid;
            s1_sof    <= sof_q;
            s1_last   <= data_last;
            s1_swap   <= d_begin[0];
            s1_en     <= d_en;
            s1_data   <= data;
            s1_mask   <= d_mask;
            s1_insert <= d_insert;
            s1_init   <= d_init;
        end
    end

    // ------------------------------------------------------------------
    // S2: beat partial sum. Beats start at even offsets, so a byte is the
    // high half of its word exactly when its lane parity equals begin[0].
    // ------------------------------------------------------------------
    logic [19:0] psum;
    logic        s2_valid, s2_sof, s2_last, s2_en;
    logic [19:0] s2_sum;
    logic [15:0] s2_insert, s2_init;

    always_comb begin
        logic [7:0] b;
        psum = '0;
        for (int i = 0; i < KW; i++) begin
            b = s1_mask[i] ? s1_data[8*i +: 8] : 8'h00;
            if (((i % 2) != 0) == s1_swap) psum = psum + {4'b0, b, 8'b0};
            else                           psum = psum + {12'b0, b};
        end
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_last   <= 1'b0;
            s2_en     <= 1'b0;
            s2_sum    <= '0;
            s2_insert <= '0;
            s2_init   <= '0;
        end else begin
            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            s2_last   <= s1_last;
            s2_en     <= s1_en;
            s2_sum    <= psum;
            s2_insert <= s1_insert;
            s2_init   <= s1_init;
        end
    end

    // ------------------------------------------------------------------
    // S3: frame accumulator. The finished sum moves to s3_acc on last so a
    // following frame can reseed acc_q in the very next cycle.
    // ------------------------------------------------------------------
    logic [31:0] acc_q, acc_next, s3_acc;
    logic        s3_valid, s3_en;
    logic [15:0] s3_insert;

    assign acc_next = (s2_sof ? {16'b0, s2_init} : acc_q) + {12'b0, s2_sum};

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            acc_q     <= '0;
            s3_acc    <= '0;
            s3_valid  <= 1'b0;
            s3_en     <= 1'b0;
            s3_insert <= '0;
        end else begin
            s3_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                acc_q <= acc_next;
                if (s2_last) begin
                    s3_acc    <= acc_next;
                    s3_en     <= s2_en;
                    s3_insert <= s2_insert;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S4: fold twice, invert, optional zero substitution
    // ------------------------------------------------------------------
    logic [16:0] fold1;
    logic [15:0] fold2, csum;
    logic        s4_valid, s4_en;
    logic [15:0] s4_sum, s4_insert;

    assign fold1 = {1'b0, s3_acc[31:16]} + {1'b0, s3_acc[15:0]};
    assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

`ifdef CSUM_ZERO_FIX_EN
    assign csum = (s3_en && (fold2 == 16'hFFFF)) ? 16'hFFFF : ~fold2;
`else
    assign csum = ~fold2;
`endif

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            s4_valid  <= 1'b0;
            s4_en     <= 1'b0;
            s4_sum    <= '0;
            s4_insert <= '0;
        end else begin
            s4_valid <= s3_valid;
            if (s3_valid) begin
                s4_en     <= s3_en;
                s4_sum    <= csum;
                s4_insert <= s3_insert;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO; a same-cycle pop makes room for the push.
    // ------------------------------------------------------------------
    logic [15:0] rq_sum    [C_RES_DEPTH];
    logic [15:0] rq_insert [C_RES_DEPTH];
    logic        rq_en     [C_RES_DEPTH];
    logic [RAW:0] rq_wr, rq_rd;
    logic rq_empty, rq_full, rq_push, rq_pop;

    assign rq_empty = (rq_wr == rq_rd);
    assign rq_full  = (rq_wr[RAW] != rq_rd[RAW]) && (rq_wr[RAW-1:0] == rq_rd[RAW-1:0]);
    assign rq_pop   = res_ready && !rq_empty;
    assign rq_push  = s4_valid && (!rq_full || rq_pop);

    always_ff @(posedge mm2s_clk) begin
        if (rq_push) begin
            rq_sum[rq_wr[RAW-1:0]]    <= s4_sum;
            rq_insert[rq_wr[RAW-1:0]] <= s4_insert;
            rq_en[rq_wr[RAW-1:0]]     <= s4_en;
        end
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            rq_wr       <= '0;
            rq_rd       <= '0;
            err_res_ovf <= 1'b0;
        end else begin
            err_res_ovf <= s4_valid && rq_full && !rq_pop;
            if (rq_push) rq_wr <= rq_wr + 1'b1;
            if (rq_pop)  rq_rd <= rq_rd + 1'b1;
        end
    end

    assign res_valid  = !rq_empty;
    assign res_sum    = rq_empty ? 16'h0000 : rq_sum[rq_rd[RAW-1:0]];
    assign res_insert = rq_empty ? 16'h0000 : rq_insert[rq_rd[RAW-1:0]];
    assign res_en     = rq_empty ? 1'b0     : rq_en[rq_rd[RAW-1:0]];

endmodule
